// File: rtl/muldiv_sched_pkg.sv
// Shared types for the two-lane multiply/divide scheduler.
package muldiv_sched_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_t;

   localparam int MUL_LAT_DEFAULT = 4;

   function automatic logic op_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic op_is_signed(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so the result is ready 32 cycles after start.
module div_radix2
   import muldiv_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] div_q;
   logic [5:0]  cnt;

   // One restoring step: quotient register carries the unconsumed dividend bits.
   function automatic logic [63:0] step(input logic [31:0] r_in,
                                        input logic [31:0] q_in,
                                        input logic [31:0] d);
      logic [32:0] r;
      logic [32:0] diff;
      logic        qb;
      r    = {r_in, q_in[31]};
      diff = r - {1'b0, d};
      qb   = ~diff[32];
      return {(qb ? diff[31:0] : r[31:0]), q_in[30:0], qb};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         quotient  <= '0;
         remainder <= '0;
         div_q     <= '0;
         cnt       <= '0;
      end else if (start) begin
         {remainder, quotient} <= step(32'd0, a, b);
         div_q                 <= b;
         cnt                   <= 6'd1;
      end else if (cnt != 6'd0 && cnt != 6'd32) begin
         {remainder, quotient} <= step(remainder, quotient, div_q);
         cnt                   <= cnt + 6'd1;
      end
   end

   assign done = (cnt == 6'd32);

endmodule

// File: rtl/muldiv_sched.sv
// Two-lane HI/LO multiply/divide controller: serialises lane 1 then lane 0,
// stalls the pipeline while any valid lane lacks a result.
module muldiv_sched
   import muldiv_sched_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [1:0][1:0]  req_op,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic             stall_in,
   input  logic             flush,
   output logic             busy,
   output logic [1:0]       res_valid,
   output logic [1:0][63:0] res_hilo
);

   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

   md_state_t   state;
   logic        lane;
   logic        sign_a, sign_b;
   logic [31:0] mag_a_p0, mag_b_p0;
   logic [2:0]  cnt;
   logic [63:0] mul_p0, prod_p1, prod_src;
   logic [1:0]  pend, cand;
   logic        complete, start_go, start_sel, sel_sgn, div_start;
   md_op_t      sel_op;
   logic [31:0] sel_mag_a, sel_mag_b;
   logic [31:0] quo, rem, fin_hi, fin_lo;
   logic        div_done;
   logic [63:0] fin_hilo;

   function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
      return (sgn && v < 0) ? 32'(-v) : 32'(v);
   endfunction

   function automatic logic [31:0] fix32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] fix64(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

   always_comb begin
      pend     = req_valid & ~res_valid;
      busy     = |pend;
      complete = (state == MUL && cnt == MUL_LAST) || (state == DIV && div_done);
      cand     = 2'b00;
      if (state == IDLE)
         cand = pend;
      else if (complete)
         cand = pend & ~(2'b01 << lane);
      start_go  = |cand;
      start_sel = cand[1];
      sel_op    = md_op_t'(req_op[start_sel]);
      sel_sgn   = op_is_signed(sel_op);
      sel_mag_a = mag32($signed(req_a[start_sel]), sel_sgn);
      sel_mag_b = mag32($signed(req_b[start_sel]), sel_sgn);
      div_start = start_go & op_is_div(sel_op) & ~flush;
   end

   // Multiply stage: magnitudes (p0) -> registered product (p1)
   always_comb begin
      mul_p0   = 64'(mag_a_p0) * 64'(mag_b_p0);
      prod_src = (MUL_LAT == 1) ? mul_p0 : prod_p1;
      fin_lo   = (mag_b_p0 == 32'd0) ? 32'hFFFF_FFFF : fix32(quo, sign_a ^ sign_b);
      fin_hi   = fix32(rem, sign_a);
      fin_hilo = (state == DIV) ? {fin_hi, fin_lo} : fix64(prod_src, sign_a ^ sign_b);
   end

   div_radix2 u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .a         (sel_mag_a),
      .b         (sel_mag_b),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lane      <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         mag_a_p0  <= '0;
         mag_b_p0  <= '0;
         cnt       <= '0;
         prod_p1   <= '0;
         res_valid <= '0;
         res_hilo  <= '0;
      end else begin
         prod_p1 <= mul_p0;
         if (flush) begin
            state     <= IDLE;
            res_valid <= '0;
         end else begin
            case (state)
               MUL:     if (!complete) cnt <= cnt + 3'd1;
               DONE:    if (!stall_in) begin
                           state     <= IDLE;
                           res_valid <= '0;
                        end
               default: ;
            endcase
            if (complete) begin
               res_valid[lane] <= 1'b1;
               res_hilo[lane]  <= fin_hilo;
               if (!start_go) state <= DONE;
            end
            // Start edge: the next op begins on the same edge, no bubble
            if (start_go) begin
               lane     <= start_sel;
               sign_a   <= sel_sgn & req_a[start_sel][31];
               sign_b   <= sel_sgn & req_b[start_sel][31];
               mag_a_p0 <= sel_mag_a;
               mag_b_p0 <= sel_mag_b;
               cnt      <= '0;
               state    <= op_is_div(sel_op) ? DIV : MUL;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: directed edge cases plus randomized single/dual-lane
// traffic against an arithmetic reference model.
module tb_muldiv_sched;
   import muldiv_sched_pkg::*;

   localparam int MUL_LAT = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0][1:0]  req_op;
   logic [1:0][31:0] req_a, req_b;
   logic             stall_in, flush;
   logic             busy;
   logic [1:0]       res_valid;
   logic [1:0][63:0] res_hilo;

   int tests_run = 0;
   int tests_failed = 0;

   muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .stall_in  (stall_in),
      .flush     (flush),
      .busy      (busy),
      .res_valid (res_valid),
      .res_hilo  (res_hilo)
   );

   always #5 clk = ~clk;

   function automatic int model_lat(input logic [1:0] op);
      return (op == MD_DIV || op == MD_DIVU) ? 32 : MUL_LAT;
   endfunction

   function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sp;
      longint unsigned up;
      int              q, r;
      case (op)
         MD_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         MD_MULTU: begin
            up = 64'(a) * 64'(b);
            return up;
         end
         MD_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {r, q};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom % 6)
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom % 16);
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic set_idle();
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      stall_in  = 1'b0;
      flush     = 1'b0;
   endtask

   // Presents a request in a new cycle 0 and follows it until busy drops.
   task automatic run_req(input logic [1:0] v, input logic stall,
                          input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          output int low, output int rv1, output int rv0,
                          output logic [63:0] h1, output logic [63:0] h0);
      @(posedge clk); #1;
      flush     = 1'b0;
      stall_in  = stall;
      req_valid = v;
      req_op[1] = op1;  req_a[1] = a1;  req_b[1] = b1;
      req_op[0] = op0;  req_a[0] = a0;  req_b[0] = b0;
      low = -1;  rv1 = -1;  rv0 = -1;  h1 = '0;  h0 = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (res_valid[1] && rv1 < 0) begin rv1 = c; h1 = res_hilo[1]; end
         if (res_valid[0] && rv0 < 0) begin rv0 = c; h0 = res_hilo[0]; end
         if (!busy) begin low = c; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic release_req();
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic test_reset();
      set_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (res_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_res_valid: got %b expected 00", res_valid); end
      tests_run++;
      if (res_hilo !== '0) begin tests_failed++; $display("FAIL reset_res_hilo: got %h expected 0", res_hilo); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_mult_edge();
      int low, rv1, rv0;
      logic [63:0] h1, h0;
      run_req(2'b10, 1'b0, MD_MULT, 32'hFFFF_FFFF, 32'd2, MD_MULT, 32'd0, 32'd0, low, rv1, rv0, h1, h0);
      tests_run++;
      if (low !== 5) begin tests_failed++; $display("FAIL mult_busy_low: got cycle %0d expected 5", low); end
      tests_run++;
      if (rv1 !== 5) begin tests_failed++; $display("FAIL mult_rv1: got cycle %0d expected 5", rv1); end
      tests_run++;
      if (res_valid !== 2'b10) begin tests_failed++; $display("FAIL mult_res_valid: got %b expected 10", res_valid); end
      tests_run++;
      if (h1 !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL mult_hilo: got %h expected fffffffffffffffe", h1); end
      release_req();
   endtask

   task automatic test_div_edges();
      int low, rv1, rv0;
      logic [63:0] h1, h0;
      run_req(2'b01, 1'b0, MD_MULT, 32'd0, 32'd0, MD_DIVU, 32'd7, 32'd0, low, rv1, rv0, h1, h0);
      tests_run++;
      if (low !== 33) begin tests_failed++; $display("FAIL divz_busy_low: got cycle %0d expected 33", low); end
      tests_run++;
      if (h0 !== {32'd7, 32'hFFFF_FFFF}) begin tests_failed++; $display("FAIL divz_hilo: got %h expected 00000007ffffffff", h0); end
      release_req();
      run_req(2'b01, 1'b0, MD_MULT, 32'd0, 32'd0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, low, rv1, rv0, h1, h0);
      tests_run++;
      if (low !== 33) begin tests_failed++; $display("FAIL divovf_busy_low: got cycle %0d expected 33", low); end
      tests_run++;
      if (h0 !== {32'd0, 32'h8000_0000}) begin tests_failed++; $display("FAIL divovf_hilo: got %h expected 0000000080000000", h0); end
      release_req();
   endtask

   task automatic test_dual_lane();
      int low, rv1, rv0;
      logic [63:0] h1, h0;
      run_req(2'b11, 1'b0, MD_DIV, 32'hFFFF_FFF9, 32'd2, MD_MULTU, 32'd3, 32'd5, low, rv1, rv0, h1, h0);
      tests_run++;
      if (rv1 !== 33) begin tests_failed++; $display("FAIL dual_rv1: got cycle %0d expected 33", rv1); end
      tests_run++;
      if (h1 !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin tests_failed++; $display("FAIL dual_hilo1: got %h expected fffffffffffffffd", h1); end
      tests_run++;
      if (rv0 !== 37) begin tests_failed++; $display("FAIL dual_rv0: got cycle %0d expected 37", rv0); end
      tests_run++;
      if (h0 !== 64'd15) begin tests_failed++; $display("FAIL dual_hilo0: got %h expected 000000000000000f", h0); end
      tests_run++;
      if (low !== 37) begin tests_failed++; $display("FAIL dual_busy_low: got cycle %0d expected 37", low); end
      release_req();
   endtask

   task automatic test_stall();
      int low, rv1, rv0;
      logic [63:0] h1, h0, exp;
      logic [31:0] a, b;
      a = $urandom;  b = $urandom;
      exp = model_res(MD_MULTU, a, b);
      run_req(2'b01, 1'b1, MD_MULT, 32'd0, 32'd0, MD_MULTU, a, b, low, rv1, rv0, h1, h0);
      tests_run++;
      if (low !== MUL_LAT + 1) begin tests_failed++; $display("FAIL stall_busy_low: got cycle %0d expected %0d", low, MUL_LAT + 1); end
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         tests_run++;
         if (res_valid !== 2'b01) begin tests_failed++; $display("FAIL stall_hold_valid: got %b expected 01", res_valid); end
         tests_run++;
         if (res_hilo[0] !== exp) begin tests_failed++; $display("FAIL stall_hold_hilo: got %h expected %h", res_hilo[0], exp); end
      end
      @(posedge clk); #1;
      stall_in = 1'b0;
      @(negedge clk);
      tests_run++;
      if (res_valid !== 2'b01) begin tests_failed++; $display("FAIL stall_fall_valid: got %b expected 01", res_valid); end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      tests_run++;
      if (res_valid !== 2'b00) begin tests_failed++; $display("FAIL stall_clear_valid: got %b expected 00", res_valid); end
   endtask

   task automatic test_flush();
      int low, rv1, rv0;
      logic [63:0] h1, h0, exp;
      logic [31:0] a, b;
      @(posedge clk); #1;
      req_valid = 2'b01;
      req_op[0] = MD_DIVU;
      req_a[0]  = $urandom;
      req_b[0]  = 32'($urandom_range(1, 1000));
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_busy_c10: got %b expected 1", busy); end
      a = $urandom;  b = $urandom;
      exp = model_res(MD_MULTU, a, b);
      run_req(2'b10, 1'b0, MD_MULTU, a, b, MD_DIVU, 32'd0, 32'd0, low, rv1, rv0, h1, h0);
      tests_run++;
      if (rv0 !== -1) begin tests_failed++; $display("FAIL flush_lane0_valid: got cycle %0d expected none (-1)", rv0); end
      tests_run++;
      if (low !== MUL_LAT + 1) begin tests_failed++; $display("FAIL flush_new_busy_low: got cycle %0d expected %0d", low, MUL_LAT + 1); end
      tests_run++;
      if (h1 !== exp) begin tests_failed++; $display("FAIL flush_new_hilo: got %h expected %h", h1, exp); end
      release_req();
   endtask

   task automatic test_reset_mid();
      int low, rv1, rv0;
      logic [63:0] h1, h0, exp;
      logic [31:0] a, b;
      @(posedge clk); #1;
      req_valid = 2'b10;
      req_op[1] = MD_MULT;
      req_a[1]  = $urandom;
      req_b[1]  = $urandom;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      tests_run++;
      if (res_valid !== 2'b00) begin tests_failed++; $display("FAIL rstmid_res_valid: got %b expected 00", res_valid); end
      tests_run++;
      if (res_hilo !== '0) begin tests_failed++; $display("FAIL rstmid_res_hilo: got %h expected 0", res_hilo); end
      a = pick_operand();  b = pick_operand();
      exp = model_res(MD_DIV, a, b);
      run_req(2'b01, 1'b0, MD_MULT, 32'd0, 32'd0, MD_DIV, a, b, low, rv1, rv0, h1, h0);
      tests_run++;
      if (low !== 33) begin tests_failed++; $display("FAIL rstmid_new_busy_low: got cycle %0d expected 33", low); end
      tests_run++;
      if (h0 !== exp) begin tests_failed++; $display("FAIL rstmid_new_hilo: got %h expected %h", h0, exp); end
      release_req();
   endtask

   // Odd iterations leave the request up so the next one follows back to back.
   task automatic test_random_back_to_back();
      int low, rv1, rv0, l1, l0, exp_rv1, exp_rv0, exp_low;
      logic [63:0] h1, h0, e1, e0;
      logic [1:0]  v, op1, op0;
      logic [31:0] a1, b1, a0, b0;
      for (int it = 0; it < 24; it++) begin
         v   = 2'($urandom_range(1, 3));
         op1 = 2'($urandom);  op0 = 2'($urandom);
         a1  = pick_operand(); b1 = pick_operand();
         a0  = pick_operand(); b0 = pick_operand();
         e1  = model_res(op1, a1, b1);
         e0  = model_res(op0, a0, b0);
         l1  = model_lat(op1);
         l0  = model_lat(op0);
         exp_rv1 = v[1] ? l1 + 1 : -1;
         exp_rv0 = v[0] ? (v[1] ? l1 + l0 + 1 : l0 + 1) : -1;
         exp_low = v[0] ? exp_rv0 : exp_rv1;
         run_req(v, 1'b0, op1, a1, b1, op0, a0, b0, low, rv1, rv0, h1, h0);
         tests_run++;
         if (low !== exp_low) begin tests_failed++; $display("FAIL rnd%0d_busy_low: got cycle %0d expected %0d", it, low, exp_low); end
         tests_run++;
         if (rv1 !== exp_rv1) begin tests_failed++; $display("FAIL rnd%0d_rv1: got cycle %0d expected %0d", it, rv1, exp_rv1); end
         tests_run++;
         if (rv0 !== exp_rv0) begin tests_failed++; $display("FAIL rnd%0d_rv0: got cycle %0d expected %0d", it, rv0, exp_rv0); end
         tests_run++;
         if (res_valid !== v) begin tests_failed++; $display("FAIL rnd%0d_res_valid: got %b expected %b", it, res_valid, v); end
         if (v[1]) begin
            tests_run++;
            if (h1 !== e1) begin tests_failed++; $display("FAIL rnd%0d_hilo1 op%0d %h,%h: got %h expected %h", it, op1, a1, b1, h1, e1); end
         end
         if (v[0]) begin
            tests_run++;
            if (h0 !== e0) begin tests_failed++; $display("FAIL rnd%0d_hilo0 op%0d %h,%h: got %h expected %h", it, op0, a0, b0, h0, e0); end
         end
         if (it % 2 == 0) release_req();
      end
      release_req();
   endtask

   initial begin
      reset = 1'b1;
      set_idle();
      test_reset();
      test_mult_edge();
      test_div_edges();
      test_dual_lane();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 Parameter MUL_LAT, default 4, multiply occupancy in cycles (legal 1..8).
REQ-002 Clock and reset are one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  per-lane request; lane 1 is the older slot.
REQ-006 req_op  in  2x2  per-lane op: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
REQ-007 req_a, req_b  in  2x32  per-lane rs/rt operands, already bypass-resolved; held stable while busy or stall_in.
REQ-008 stall_in  in  1  downstream stall; high means the pipeline holds this stage.
REQ-009 flush  in  1  kill all in-flight work.
REQ-010 busy  out  1  stage-stall request to the pipeline.
REQ-011 res_valid  out  2  per-lane result ready.
REQ-012 res_hilo  out  2x64  per-lane {hi,lo} result.

Function
REQ-013 FSM states: IDLE, MUL, DIV, DONE.
REQ-014 busy = OR over lanes of (req_valid[i] & ~res_valid[i]), combinational.
- Holds in every state, including cycle 0 of a request.
REQ-015 Starting a request (IDLE, or on completion with a lane still pending):
- Select lane 1 if pending, else lane 0.
- Latch |a|, |b|, sign flags (signed ops only) and lane id.
- Enter MUL or DIV.
REQ-016 MUL lasts exactly MUL_LAT cycles; the product of the latched magnitudes is then written to the lane's result.
REQ-017 DIV lasts exactly 32 cycles, driving the sub-module; quotient to lo, remainder to hi.
REQ-018 Signed results:
- Product negated when the sign flags differ.
- Quotient negated when the sign flags differ.
- Remainder takes the sign of the dividend.
- All arithmetic is mod 2^32 / 2^64.
REQ-019 Edge cases (no exception is raised for either):
- Divide by zero completes in 32 cycles with lo=0xFFFFFFFF and hi=dividend (after sign rule).
- 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
REQ-020 On completion:
- Set res_valid[lane] and write res_hilo[lane].
- If the other lane has req_valid and is not done, start it on the same edge with no bubble.
- Otherwise go to DONE.
REQ-021 DONE:
- Hold results while stall_in=1.
- When stall_in=0, go to IDLE and clear res_valid on that edge.
REQ-022 Cycle counts (start edge = end of cycle 0): a single MULT drops busy in cycle MUL_LAT+1; a single DIV drops busy in cycle 33; lane 1 MULT plus lane 0 DIV drops busy in cycle MUL_LAT+33.
REQ-023 Flush has priority over everything else:
- Next state IDLE; res_valid cleared.
- Divider aborted; its state is don't-care.
REQ-024 A lane whose req_valid drops mid-operation is not required to produce a meaningful result; the controller completes the current op and ignores it.
REQ-025 res_hilo for a lane with res_valid=0 is don't-care.

Reset
REQ-026 Reset drives:
- State to IDLE.
- res_valid to 0.
- res_hilo to 0.
- Latched operands, sign flags and counters to 0.
REQ-027 A reset asserted mid-operation overrides flush and all requests; busy follows REQ-014 in the next cycle.

Structure
REQ-028 A shared package holds the md_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the state enum and MUL_LAT_DEFAULT.
REQ-029 Sub-module div_radix2: unsigned restoring divider, one bit per cycle.
- Ports: start, a, b, quotient, remainder, done.
- The controller owns signs and sequencing.
REQ-030 The multiply is a registered unsigned 32x32 product that the controller counts out; it is not a separate module.

Verification (MUL_LAT=4)
REQ-031 Lane 1 MULT 0xFFFFFFFF x 2 -> busy high cycles 0-4; cycle 5 res_valid=2'b10, res_hilo[1]=0xFFFFFFFF_FFFFFFFE.
REQ-032 Lane 0 DIVU 7 / 0 -> busy low cycle 33, res_hilo[0]={0x00000007,0xFFFFFFFF}.
REQ-033 Both lanes valid (lane 1 DIV -7/2, lane 0 MULTU 3x5):
- Lane 1 first: res_hilo[1]={0xFFFFFFFF,0xFFFFFFFD}.
- Lane 0 next: res_hilo[0]={0,15}.
- busy low at cycle 37.
REQ-034 Completion with stall_in=1 for 3 cycles -> results and res_valid held steady; cleared on the edge stall_in falls.
REQ-035 Flush at cycle 10 of a DIV -> IDLE next cycle, res_valid=0; a new MULT issued immediately completes in MUL_LAT cycles.
REQ-036 Reset at cycle 2 of a MULT -> all outputs zero next cycle; a new request runs normally.
